// File: rtl/uart_rx_oversampled_if.sv
// Receiver-side bundle for uart_rx_oversampled: oversampling strobe and
// serial line in, received word plus status out.
// master : baud generator / line driver side (drives s_tick, rx)
// slave  : receiver side (drives dout and status)
interface uart_rx_oversampled_if #(
  parameter int DBIT = 8
);
  logic            s_tick;
  logic            rx;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;
  logic            parity_err;

  modport master (
    output s_tick, rx,
    input  dout, rx_done_tick, frame_err, parity_err
  );

  modport slave (
    input  s_tick, rx,
    output dout, rx_done_tick, frame_err, parity_err
  );
endinterface

// File: rtl/uart_rx_oversampled.sv
// 16x oversampled UART receiver.
// Frame: start bit, DBIT data bits LSB first, optional even-parity bit,
// stop bit(s) lasting SB_TICK oversampling ticks. Each bit is sampled at
// its centre: the start bit is confirmed 8 ticks after the falling edge,
// every later bit 16 ticks after the previous sample.
// Optional feature macro: UART_RX_PARITY_EN (adds a PARITY state and a live
// parity_err output; otherwise parity_err is tied low).
module uart_rx_oversampled #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_rx_oversampled_if.slave   bus
);

  // Tick counter must reach both 15 (data bits) and SB_TICK-1 (stop bits).
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state_q;
  logic [SW-1:0]   s_q;
  logic [NW-1:0]   n_q;
  logic [DBIT-1:0] b_q;
  logic [DBIT-1:0] dout_q;
  logic            done_q;
  logic            ferr_q;
  logic            perr_q;
  logic [1:0]      sync_q;
  logic            rx_s;
`ifdef UART_RX_PARITY_EN
  logic            par_q;
`endif

  // Two-flop synchronizer for the asynchronous line; resets to idle-high so
  // reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], bus.rx};
  end

  assign rx_s = sync_q[1];

  // Receive FSM with counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // Falling edge starts the tick count immediately, tick or not.
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            s_q     <= '0;
          end
        end

        // Confirm the start bit at its centre; a high sample is a glitch.
        START: begin
          if (bus.s_tick) begin
            if (s_q == SW'(7)) begin
              if (!rx_s) begin
                state_q <= DATA;
                s_q     <= '0;
                n_q     <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end

        // Shift in one data bit per 16 ticks, LSB first.
        DATA: begin
          if (bus.s_tick) begin
            if (s_q == SW'(15)) begin
              s_q <= '0;
              b_q <= {rx_s, b_q[DBIT-1:1]};
              if (n_q == NW'(DBIT-1)) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end else begin
                n_q <= n_q + NW'(1);
              end
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        // Parity bit is sampled exactly like a data bit.
        PARITY: begin
          if (bus.s_tick) begin
            if (s_q == SW'(15)) begin
              s_q     <= '0;
              par_q   <= rx_s;
              state_q <= STOP;
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
`endif

        // Frame completes after SB_TICK ticks: publish word and status.
        STOP: begin
          if (bus.s_tick) begin
            if (s_q == SW'(SB_TICK-1)) begin
              state_q <= IDLE;
              s_q     <= '0;
              dout_q  <= b_q;
              ferr_q  <= ~rx_s;
              done_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_q  <= (^b_q) ^ par_q;
`endif
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dout         = dout_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = ferr_q;
  assign bus.parity_err   = perr_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: s_tick every 4 clk, frames driven
// bit by bit in units of s_ticks, expected words/flags written by hand.
module tb_uart_rx_oversampled;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;
  int   done_cnt;
  int   wide_cnt;
  int   exp_done;
  logic done_prev;
  logic [1:0] tick_cnt;
`ifdef UART_RX_PARITY_EN
  logic par_v;
`endif

  uart_rx_oversampled_if #(.DBIT(8)) bus ();

  uart_rx_oversampled #(.DBIT(8), .SB_TICK(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-clk-wide s_tick every 4 clk, changed on the falling edge.
  initial tick_cnt = 2'd0;
  always @(negedge clk) begin
    tick_cnt   <= tick_cnt + 2'd1;
    bus.s_tick <= (tick_cnt == 2'd3);
  end

  // Count done pulses and flag any pulse longer than one cycle.
  initial begin done_cnt = 0; wide_cnt = 0; done_prev = 1'b0; end
  always @(negedge clk) begin
    if (bus.rx_done_tick) begin
      done_cnt <= done_cnt + 1;
      if (done_prev) wide_cnt <= wide_cnt + 1;
    end
    done_prev <= bus.rx_done_tick;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!bus.s_tick) @(posedge clk);
    end
    #1;
  endtask

  // Full frame; a low stop bit is released early so the receiver's
  // re-armed start check sees the line high again.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    bus.rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      wait_ticks(16);
    end
`ifdef UART_RX_PARITY_EN
    bus.rx = par_v;
    wait_ticks(16);
`endif
    if (stop_bit) begin
      bus.rx = 1'b1;
      wait_ticks(16);
    end else begin
      bus.rx = 1'b0;
      wait_ticks(12);
      bus.rx = 1'b1;
      wait_ticks(4);
    end
    bus.rx = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_err = 0; exp_done = 0;
    bus.rx = 1'b1;
    rst = 1'b1;
`ifdef UART_RX_PARITY_EN
    par_v = 1'b0;
`endif
    repeat (4) @(posedge clk);
    #1;
    chk("rst_dout", 32'(bus.dout), 32'h0);
    chk("rst_done", 32'(bus.rx_done_tick), 32'h0);
    chk("rst_ferr", 32'(bus.frame_err), 32'h0);
    chk("rst_perr", 32'(bus.parity_err), 32'h0);
    rst = 1'b0;
    wait_ticks(4);

    // Clean frame.
`ifdef UART_RX_PARITY_EN
    par_v = 1'b0;
`endif
    send_frame(8'h55, 1'b1); exp_done++;
    chk("f55_done", 32'(done_cnt), 32'(exp_done));
    chk("f55_dout", 32'(bus.dout), 32'h55);
    chk("f55_ferr", 32'(bus.frame_err), 32'h0);
`ifndef UART_RX_PARITY_EN
    chk("f55_perr", 32'(bus.parity_err), 32'h0);
`endif

    // Framing error, then recovery.
`ifdef UART_RX_PARITY_EN
    par_v = 1'b0;
`endif
    send_frame(8'hA3, 1'b0); exp_done++;
    chk("fa3_done", 32'(done_cnt), 32'(exp_done));
    chk("fa3_dout", 32'(bus.dout), 32'hA3);
    chk("fa3_ferr", 32'(bus.frame_err), 32'h1);
    wait_ticks(20);
    send_frame(8'h3C, 1'b1); exp_done++;
    chk("f3c_done", 32'(done_cnt), 32'(exp_done));
    chk("f3c_dout", 32'(bus.dout), 32'h3C);
    chk("f3c_ferr", 32'(bus.frame_err), 32'h0);

    // Start-bit glitch: 3 ticks low.
    bus.rx = 1'b0;
    wait_ticks(3);
    bus.rx = 1'b1;
    wait_ticks(12);
    chk("glitch_done", 32'(done_cnt), 32'(exp_done));
    chk("glitch_dout", 32'(bus.dout), 32'h3C);
    send_frame(8'h81, 1'b1); exp_done++;
    chk("f81_done", 32'(done_cnt), 32'(exp_done));
    chk("f81_dout", 32'(bus.dout), 32'h81);

    // Reset after 4 data bits of 0xFF.
    bus.rx = 1'b0;
    wait_ticks(16);
    bus.rx = 1'b1;
    wait_ticks(64);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ticks(20);
    chk("rstmid_done", 32'(done_cnt), 32'(exp_done));
    chk("rstmid_dout", 32'(bus.dout), 32'h0);
    chk("rstmid_ferr", 32'(bus.frame_err), 32'h0);
    chk("rstmid_perr", 32'(bus.parity_err), 32'h0);
    send_frame(8'h0F, 1'b1); exp_done++;
    chk("f0f_done", 32'(done_cnt), 32'(exp_done));
    chk("f0f_dout", 32'(bus.dout), 32'h0F);

    // Back-to-back frames.
    send_frame(8'h12, 1'b1); exp_done++;
    chk("f12_done", 32'(done_cnt), 32'(exp_done));
    chk("f12_dout", 32'(bus.dout), 32'h12);
    send_frame(8'h34, 1'b1); exp_done++;
    chk("f34_done", 32'(done_cnt), 32'(exp_done));
    chk("f34_dout", 32'(bus.dout), 32'h34);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: parity bit 1 matches, 0 mismatches.
    par_v = 1'b1;
    send_frame(8'h07, 1'b1); exp_done++;
    chk("p1_done", 32'(done_cnt), 32'(exp_done));
    chk("p1_perr", 32'(bus.parity_err), 32'h0);
    par_v = 1'b0;
    send_frame(8'h07, 1'b1); exp_done++;
    chk("p0_dout", 32'(bus.dout), 32'h07);
    chk("p0_perr", 32'(bus.parity_err), 32'h1);
`else
    chk("end_perr", 32'(bus.parity_err), 32'h0);
`endif

    chk("pulse_width", 32'(wide_cnt), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversampled.md
UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

Interface
REQ-001 SHALL have parameter DBIT, default 8, data bits per frame (5..9).
REQ-002 SHALL have parameter SB_TICK, default 16, s_tick count for stop-bit sampling (16 = 1 stop bit, 32 = 2 stop bits).
REQ-003 SHALL have port clk  input  1  single system clock; all logic is clocked on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port s_tick  input  1  16x-baud oversampling strobe, one clk cycle wide, from the baud generator.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port dout  output  DBIT  last received data word, LSB received first.
REQ-008 SHALL have port rx_done_tick  output  1  one-clk pulse when a frame completes.
REQ-009 SHALL have port frame_err  output  1  stop bit sampled low on the last completed frame.
REQ-010 SHALL have port parity_err  output  1  parity mismatch on the last completed frame (present only per REQ-030).

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer (reset value 1); all sampling uses the synchronized value rx_s.
REQ-012 SHALL implement states IDLE, START, DATA, STOP (plus PARITY per REQ-030); tick counter s (4 bits), bit counter n, and shift register b.
REQ-013 IDLE: on rx_s == 0, SHALL go to START with s = 0, regardless of s_tick.
REQ-014 START: on s_tick with s == 7, if rx_s == 0 SHALL go to DATA with s = 0, n = 0; if rx_s == 1 (glitch) SHALL return to IDLE with no output change; otherwise on s_tick s increments.
REQ-015 DATA: on s_tick with s == 15, SHALL set s = 0 and shift b = {rx_s, b[DBIT-1:1]}; if n == DBIT-1, SHALL go to STOP, else n increments; otherwise on s_tick s increments.
REQ-016 STOP: on s_tick with s == SB_TICK-1 (counter widened to hold SB_TICK-1), SHALL load dout = b, set frame_err = ~rx_s, pulse rx_done_tick, and return to IDLE.
REQ-017 rx_done_tick SHALL be registered, high for exactly one clk cycle, in the cycle after the qualifying s_tick edge.
REQ-018 rx_done_tick SHALL fire on framing errors too; frame_err and parity_err qualify it and SHALL hold until the next completed frame.
REQ-019 With s_tick low, state and counters SHALL hold (except the IDLE->START transition).
REQ-020 Continuous low line (break) SHALL yield repeated frames of all-zero data with frame_err = 1; the receiver re-arms in IDLE on the next low sample.
REQ-021 dout SHALL change only at frame completion; a partial frame never alters dout.

Reset
REQ-022 With rst high at a clk edge: state = IDLE, s = 0, n = 0, b = 0, dout = 0, rx_done_tick = 0, frame_err = 0, parity_err = 0, synchronizer flops = 1.
REQ-023 Reset mid-frame SHALL abandon the frame with no rx_done_tick; the next frame after rst deasserts SHALL be received normally.
REQ-024 rst SHALL take priority over s_tick and rx in the same cycle.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined: SHALL insert PARITY state between DATA and STOP, sampled at s == 15 like a data bit; parity_err = (XOR of data bits) ^ parity bit (even parity), updated at frame completion.
REQ-031 Macro UART_RX_PARITY_EN undefined: no PARITY state; DATA goes directly to STOP; parity_err port SHALL exist and be tied 0.

Verification
REQ-040 s_tick every 4 clk, frame 0x55 with stop = 1 -> dout = 0x55, single-cycle rx_done_tick, frame_err = 0.
REQ-041 Frame 0xA3 with stop bit driven 0 -> dout = 0xA3, rx_done_tick pulses, frame_err = 1; next frame 0x3C with stop = 1 -> frame_err = 0.
REQ-042 rx low for 3 s_ticks then high -> no rx_done_tick, dout unchanged, FSM back in IDLE; following frame 0x81 received correctly.
REQ-043 rst pulsed after 4 data bits of 0xFF -> all outputs 0, no done pulse; subsequent frame 0x0F -> dout = 0x0F.
REQ-044 Back-to-back frames 0x12, 0x34 (no idle gap) -> two done pulses, dout 0x12 then 0x34.
REQ-045 UART_RX_PARITY_EN: 0x07 with parity bit 1 -> parity_err = 0; 0x07 with parity bit 0 -> parity_err = 1.
